// File: rtl/hilo_muldiv_seq.sv
// rtl/hilo_muldiv_seq.sv - multi-cycle radix-2 multiply / restoring divide sequencer for Hi/Lo
// Iterates on operand magnitudes for DATA_W cycles, then spends one cycle on sign fix-up.
module hilo_muldiv_seq #(
   parameter int DATA_W = 32
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Start,
   input  logic [2:0]            Op,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   input  logic                  Flush,
   output logic                  Busy,
   output logic                  Done,
   output logic [3:0]            HiLoEnable,
   output logic [2*DATA_W-1:0]   Product
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_WRITE
   } state_t;

   state_t state, state_nxt;

   logic [2:0]            op_q;
   logic [DATA_W-1:0]     a_q;
   logic [DATA_W-1:0]     ma_q;
   logic [DATA_W-1:0]     mb_q;
   logic                  neg_q;
   logic                  rneg_q;
   logic                  div_q;
   logic [CW-1:0]         cnt;
   logic [2*DATA_W-1:0]   acc;
   logic [2*DATA_W-1:0]   prod_q;

   logic                  accept;
   logic                  in_sgn;
   logic                  in_div;
   logic [DATA_W-1:0]     in_ma;
   logic [DATA_W-1:0]     in_mb;
   logic [DATA_W:0]       mul_sum;
   logic [DATA_W:0]       div_shift;
   logic [DATA_W:0]       div_diff;
   logic [2*DATA_W-1:0]   acc_iter;
   logic [2*DATA_W-1:0]   acc_fix;
   logic [DATA_W-1:0]     rem;
   logic [DATA_W-1:0]     quot;
   logic [3:0]            code;

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
      return (sgn && v[DATA_W-1]) ? -v : v;
   endfunction

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start && !Flush && (Op <= 3'd5)) begin
               accept    = 1'b1;
               state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            if (Flush) begin
               state_nxt = S_IDLE;
            end else if (cnt == LAST) begin
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      in_sgn = (Op == 3'd0) || (Op == 3'd2) || (Op == 3'd4) || (Op == 3'd5);
      in_div = (Op == 3'd2) || (Op == 3'd3);
      in_ma  = mag(A, in_sgn);
      in_mb  = mag(B, in_sgn);
   end

   // One shift-add or one restore step; acc holds {hi,lo} or {rem,quot}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, ma_q};
      div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
      div_diff  = div_shift - {1'b0, mb_q};
      acc_iter  = '0;
      if (div_q) begin
         if (!div_diff[DATA_W]) begin
            acc_iter = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
         end else begin
            acc_iter = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
         end
      end else begin
         if (acc[0]) begin
            acc_iter = {mul_sum, acc[DATA_W-1:1]};
         end else begin
            acc_iter = {1'b0, acc[2*DATA_W-1:1]};
         end
      end
   end

   always_comb begin
      rem     = acc[2*DATA_W-1:DATA_W];
      quot    = acc[DATA_W-1:0];
      acc_fix = acc;
      if (div_q) begin
         if (mb_q == '0) begin
            acc_fix = {a_q, {DATA_W{1'b1}}};
         end else begin
            acc_fix = {(rneg_q ? -rem : rem), (neg_q ? -quot : quot)};
         end
      end else if (neg_q) begin
         acc_fix = -acc;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         op_q   <= '0;
         a_q    <= '0;
         ma_q   <= '0;
         mb_q   <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         div_q  <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         prod_q <= '0;
      end else begin
         if (accept) begin
            op_q   <= Op;
            a_q    <= A;
            ma_q   <= in_ma;
            mb_q   <= in_mb;
            neg_q  <= in_sgn & (A[DATA_W-1] ^ B[DATA_W-1]);
            rneg_q <= in_sgn & A[DATA_W-1];
            div_q  <= in_div;
            cnt    <= '0;
            acc    <= in_div ? {{DATA_W{1'b0}}, in_ma} : {{DATA_W{1'b0}}, in_mb};
         end else if (state == S_CALC && !Flush) begin
            if (cnt != LAST) begin
               acc <= acc_iter;
               cnt <= cnt + 1'b1;
            end else begin
               acc <= acc_fix;
            end
         end
         // A flushed write never becomes the held value.
         if (state == S_WRITE && !Flush) begin
            prod_q <= acc;
         end
      end
   end

   always_comb begin
      case (op_q)
         3'd0, 3'd1: code = 4'd1;
         3'd2, 3'd3: code = 4'd3;
         3'd4:       code = 4'd4;
         3'd5:       code = 4'd5;
         default:    code = 4'd0;
      endcase
   end

   always_comb begin
      Busy       = (state != S_IDLE);
      Done       = (state == S_WRITE) && !Flush;
      HiLoEnable = Done ? code : 4'd0;
      Product    = (state == S_WRITE) ? acc : prod_q;
   end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb/tb_hilo_muldiv_seq.sv - directed vector bench for hilo_muldiv_seq
module tb_hilo_muldiv_seq;

   localparam int W = 32;

   logic            Clk = 1'b0;
   logic            Rst_n = 1'b0;
   logic            Start = 1'b0;
   logic            Flush = 1'b0;
   logic [2:0]      Op = '0;
   logic [W-1:0]    A = '0;
   logic [W-1:0]    B = '0;
   logic            Busy;
   logic            Done;
   logic [3:0]      HiLoEnable;
   logic [2*W-1:0]  Product;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [3:0]     en;
      logic [2*W-1:0] prod;
   } vec_t;

   vec_t vecs[14];

   hilo_muldiv_seq #(.DATA_W(W)) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .Start(Start),
      .Op(Op),
      .A(A),
      .B(B),
      .Flush(Flush),
      .Busy(Busy),
      .Done(Done),
      .HiLoEnable(HiLoEnable),
      .Product(Product)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      tick();
      Start = 1'b0;
   endtask

   // mode 0: plain; 1: Start (MULT 2,3) poked at cycle 10; 2: Flush during WRITE
   task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] en,
                         input logic [2*W-1:0] prod, input int mode);
      int k;
      logic [2*W-1:0] prev;
      prev = Product;
      start_op(op, a, b);
      check({name, " busy_calc"}, 64'(Busy), 64'd1);
      k = 0;
      while (k < 40 && !Done) begin
         if (mode == 1 && k == 10) begin
            Start = 1'b1;
            Op    = 3'd0;
            A     = 32'd2;
            B     = 32'd3;
         end
         tick();
         Start = 1'b0;
         k++;
      end
      check({name, " latency"}, 64'(k), 64'd33);
      check({name, " product"}, Product, prod);
      check({name, " busy_write"}, 64'(Busy), 64'd1);
      if (mode == 2) begin
         Flush = 1'b1;
         #1;
         check({name, " flushed_en"}, 64'(HiLoEnable), 64'd0);
         check({name, " flushed_done"}, 64'(Done), 64'd0);
         tick();
         Flush = 1'b0;
         check({name, " flushed_busy"}, 64'(Busy), 64'd0);
         check({name, " flushed_hold"}, Product, prev);
      end else begin
         check({name, " enable"}, 64'(HiLoEnable), 64'(en));
         tick();
         check({name, " busy_after"}, 64'(Busy), 64'd0);
         check({name, " done_after"}, 64'(Done), 64'd0);
         check({name, " hold"}, Product, prod);
      end
   endtask

   task automatic quiet_window(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (Done || HiLoEnable != 4'd0 || Busy) seen = 1'b1;
      end
      check({name, " quiet"}, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [2*W-1:0] held;

      vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 4'd1, 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         4'd1, 64'h0000_0001_FFFF_FFFE};
      vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         4'd3, 64'hFFFF_FFFF_FFFF_FFFD};
      vecs[3]  = '{3'd3, 32'd5,         32'd0,         4'd3, 64'h0000_0005_FFFF_FFFF};
      vecs[4]  = '{3'd4, 32'hFFFF_FFFE, 32'd3,         4'd4, 64'hFFFF_FFFF_FFFF_FFFA};
      vecs[5]  = '{3'd5, 32'hFFFF_FFFE, 32'd3,         4'd5, 64'hFFFF_FFFF_FFFF_FFFA};
      vecs[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 4'd3, 64'h0000_0000_8000_0000};
      vecs[7]  = '{3'd3, 32'd100,       32'd7,         4'd3, 64'h0000_0002_0000_000E};
      vecs[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 4'd1, 64'h4000_0000_0000_0000};
      vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 64'hFFFF_FFFE_0000_0001};
      vecs[10] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 4'd3, 64'h0000_0001_FFFF_FFFD};
      vecs[11] = '{3'd2, 32'hFFFF_FFFB, 32'd0,         4'd3, 64'hFFFF_FFFB_FFFF_FFFF};
      vecs[12] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 64'h0000_0000_0000_0001};
      vecs[13] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 4'd3, 64'h0000_000F_0FFF_FFFF};

      #12;
      check("reset busy", 64'(Busy), 64'd0);
      check("reset done", 64'(Done), 64'd0);
      check("reset en", 64'(HiLoEnable), 64'd0);
      check("reset product", Product, 64'd0);
      Rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].en, vecs[i].prod, 0);
      end

      // Start while busy is dropped; DIV result unaffected, no follow-on op
      run_op("poke", 3'd3, 32'd100, 32'd7, 4'd3, 64'h0000_0002_0000_000E, 1);
      quiet_window("poke", 3);

      // Flush at cycle 5 of the next op
      held = Product;
      start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
      repeat (4) tick();
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      check("flush busy", 64'(Busy), 64'd0);
      quiet_window("flush", 40);
      check("flush hold", Product, held);

      run_op("wflush", 3'd1, 32'd9, 32'd9, 4'd1, 64'd81, 2);

      // Reserved op and Flush-with-Start in IDLE are both refused
      start_op(3'd6, 32'd1, 32'd1);
      check("op6 busy", 64'(Busy), 64'd0);
      Flush = 1'b1;
      start_op(3'd0, 32'd1, 32'd1);
      Flush = 1'b0;
      check("idle flush busy", 64'(Busy), 64'd0);

      // Asynchronous reset in the middle of CALC
      start_op(3'd2, 32'd1000, 32'd3);
      repeat (10) tick();
      #2;
      Rst_n = 1'b0;
      #1;
      check("arst busy", 64'(Busy), 64'd0);
      check("arst done", 64'(Done), 64'd0);
      check("arst en", 64'(HiLoEnable), 64'd0);
      check("arst product", Product, 64'd0);
      tick();
      Rst_n = 1'b1;
      quiet_window("arst", 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
